// File: rtl/mac_scheduler.sv
// Round-robin arbiter that grants one requester at a time a burst of N_TERMS signed MAC beats.
// Optional feature macro MAC_SCHEDULER_SAT_EN: 2*DATA_W product/sum with per-beat saturation of acc.
module mac_scheduler #(
    parameter int                        N_REQ       = 4,
    parameter int                        DATA_W      = 32,
    parameter int                        N_TERMS     = 4,
    parameter logic signed [DATA_W-1:0]  WEIGHT_INIT = DATA_W'(1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        cfg_we,
    input  logic [7:0]                  cfg_idx,
    input  logic signed [DATA_W-1:0]    cfg_weight,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_data,
    output logic [7:0]                  out_src,
    output logic                        busy
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(N_TERMS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_TERMS - 1);

    logic [1:0]                 state_q, state_d;
    logic signed [DATA_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]              count_q, count_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic [GW-1:0]              last_q, last_d;
    logic signed [DATA_W-1:0]   weight_q [N_REQ];
    logic signed [DATA_W-1:0]   weight_d [N_REQ];

    logic [GW-1:0]              rr_pick;
    logic signed [DATA_W-1:0]   data_sel;
    logic signed [DATA_W-1:0]   weight_sel;
    logic                       beat;
    logic                       cfg_hit;

`ifdef MAC_SCHEDULER_SAT_EN
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [2*DATA_W-1:0] s);
        logic signed [2*DATA_W-1:0] hi;
        logic signed [2*DATA_W-1:0] lo;
        hi = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = ~hi;
        if (s > hi)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (s < lo)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return s[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] mac(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] d,
                                                     input logic signed [DATA_W-1:0] w);
        logic signed [2*DATA_W-1:0] ae;
        logic signed [2*DATA_W-1:0] de;
        logic signed [2*DATA_W-1:0] we;
        ae = a;
        de = d;
        we = w;
        return sat(ae + de * we);
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] mac(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] d,
                                                     input logic signed [DATA_W-1:0] w);
        logic signed [DATA_W-1:0] prod;
        prod = d * w;
        return a + prod;
    endfunction
`endif

    // First valid requester strictly after last_grant, wrapping around.
    always_comb begin
        int idx;
        logic found;
        rr_pick = last_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                rr_pick = GW'(idx);
                found   = 1'b1;
            end
        end
    end

    assign data_sel   = req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign weight_sel = weight_q[grant_q];
    assign beat       = (state_q == S_ACCUM) && req_valid[grant_q];
    assign cfg_hit    = cfg_we && (int'(cfg_idx) < N_REQ);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d   = mac(acc_q, data_sel, weight_sel);
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_BEAT)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Weight writes land on the next edge in any state, so a write to the
    // granted index takes effect from the following beat.
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            weight_d[i] = weight_q[i];
        if (cfg_hit)
            weight_d[cfg_idx[GW-1:0]] = cfg_weight;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            grant_q <= '0;
            last_q  <= LAST_INIT;
            for (int i = 0; i < N_REQ; i++)
                weight_q[i] <= WEIGHT_INIT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            for (int i = 0; i < N_REQ; i++)
                weight_q[i] <= weight_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = (state_q == S_ACCUM) && (grant_q == GW'(i));
    end

    assign out_valid = (state_q == S_DONE);
    assign out_data  = (state_q == S_DONE) ? acc_q : '0;
    assign out_src   = (state_q == S_DONE) ? 8'(grant_q) : 8'd0;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the multiply-accumulate datapath.
REQ-002 SHALL have parameter DATA_W, default 32: signed data, weight and result width.
REQ-003 SHALL have parameter N_TERMS, default 4: accepted beats per burst, range 1..256.
REQ-004 SHALL have parameter WEIGHT_INIT, default 1: signed reset value of every weight register.
REQ-005 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  N_REQ: per-requester data valid.
REQ-008 SHALL have port req_data  in  N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready  out  N_REQ: per-requester accept, one-hot or zero.
REQ-010 SHALL have port cfg_we  in  1: weight write strobe.
REQ-011 SHALL have port cfg_idx  in  8: weight register index.
REQ-012 SHALL have port cfg_weight  in  DATA_W: signed weight value.
REQ-013 SHALL have port out_valid  out  1: burst result valid.
REQ-014 SHALL have port out_ready  in  1: downstream accept.
REQ-015 SHALL have port out_data  out  DATA_W: accumulated result.
REQ-016 SHALL have port out_src  out  8: index of the requester that produced out_data.
REQ-017 SHALL have port busy  out  1: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, ACCUM and DONE.
REQ-019 IDLE: if any req_valid bit is high, SHALL grant the first valid requester after last_grant in round-robin order, clear acc and count, and enter ACCUM on the next cycle.
REQ-020 ACCUM: SHALL drive req_ready high only for the granted requester; a beat is accepted when req_valid and req_ready are both high on the granted requester.
REQ-021 Each accepted beat SHALL add req_data × weight[grant], signed, to acc and increment count.
REQ-022 A deasserted req_valid on the granted requester SHALL stall the burst, with acc and count held; the grant is not released.
REQ-023 After the beat that makes count equal N_TERMS, the block SHALL enter DONE on the next cycle.
REQ-024 DONE: SHALL drive out_valid=1, out_data=acc and out_src=grant, and all req_ready bits SHALL be 0.
REQ-025 DONE: out_data and out_src SHALL stay stable until out_ready is high; on that cycle last_grant is set to grant and the state returns to IDLE.
REQ-026 Latency: out_valid SHALL rise exactly 1 cycle after the final beat is accepted. Minimum burst period is N_TERMS+2 cycles.
REQ-027 Default arithmetic: the product SHALL be truncated to its low DATA_W bits, and the accumulation SHALL wrap modulo 2^DATA_W.
REQ-028 A cfg_we write SHALL update weight[cfg_idx] on the next edge.
REQ-029 A write to the granted index during ACCUM SHALL apply from the following beat.
REQ-030 A write with cfg_idx ≥ N_REQ SHALL be ignored.
REQ-031 Writes SHALL be accepted in every state.
REQ-032 A requester asserting req_valid in IDLE while others are valid SHALL wait at most N_REQ-1 bursts.

Reset
REQ-033 When rst_n is low, the block SHALL immediately force state=IDLE, acc=0, count=0, grant=0 and last_grant=N_REQ-1, so that requester 0 has first priority.
REQ-034 When rst_n is low, all weights SHALL be set to WEIGHT_INIT.
REQ-035 When rst_n is low, the outputs SHALL be req_ready=0, out_valid=0, out_data=0, out_src=0 and busy=0.
REQ-036 Reset asserted mid-burst SHALL discard the partial sum with no output produced.

Configuration
REQ-037 With the macro MAC_SCHEDULER_SAT_EN defined, the product and the sum SHALL be formed at 2*DATA_W bits and acc saturated each beat to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-038 Without MAC_SCHEDULER_SAT_EN, the wrap behaviour of REQ-027 SHALL apply and no saturation logic SHALL be present.

Verification (N_REQ=4, N_TERMS=4, DATA_W=32)
REQ-039 Set cfg weight[0]=-3 and feed requester 0 data 1,2,3,4 -> out_data=0xFFFFFFE2 (-30), out_src=0.
REQ-040 Hold all four req_valid high continuously -> bursts are granted in the order 0,1,2,3,0, each burst N_TERMS+2 cycles with out_ready=1.
REQ-041 Set weight[1]=2 and feed data 0x7FFFFFFF ×4 -> out_data=0xFFFFFFF8 without the macro, 0x7FFFFFFF with MAC_SCHEDULER_SAT_EN.
REQ-042 Hold out_ready low for 5 cycles in DONE -> out_valid, out_data and out_src are stable, req_ready=0, busy=1; the handshake completes on the 6th cycle.
REQ-043 Drop rst_n after 2 beats of a burst -> outputs are 0 immediately, weights read back as WEIGHT_INIT, and the next burst grants requester 0.
REQ-044 Write cfg_idx=5 -> no weight changes. Write weight[2]=10 after beat 2 of a requester-2 burst with weight 1 and data 1 ×4 -> out_data=22.
